// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// A fetch is INST_BYTES single-byte reads assembled little-endian into one word.
package inst_fetch_pkg;

    localparam int INST_BYTES = 4;

    // Counters run 0..INST_BYTES, so three bits are enough.
    localparam logic [2:0] LAST_IDX = 3'(INST_BYTES - 1);
    localparam logic [2:0] FULL_CNT = 3'(INST_BYTES);

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_FETCH,
        IF_WAIT,
        IF_VALID
    } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: issues four byte reads, assembles the word and offers
// (pc, inst) to IF/ID; a taken branch from decode squashes and restarts.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br,
    input  logic [31:0] br_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  req_cnt_q, req_cnt_d;
    logic [2:0]  rsp_cnt_q, rsp_cnt_d;
    logic [31:0] inst_q, inst_d;
    logic        issued_q, issued_d;

    logic        grant;
    logic        last_grant;
    logic        byte_take;
    logic        last_byte;
    logic        unused_br_lsbs;

    assign mem_req  = (state_q == IF_FETCH);
    assign mem_addr = pc_q + {29'd0, req_cnt_q};
    // Gated by br so a wrong-path word is never accepted in the branch cycle.
    assign if_valid = (state_q == IF_VALID) && !br;
    assign if_pc    = pc_q;
    assign if_inst  = inst_q;

    assign grant      = mem_req && mem_gnt;
    assign last_grant = grant && (req_cnt_q == LAST_IDX);
    assign byte_take  = mem_rvalid && issued_q && (rsp_cnt_q != FULL_CNT) &&
                        ((state_q == IF_FETCH) || (state_q == IF_WAIT));
    assign last_byte  = byte_take && (rsp_cnt_q == LAST_IDX);

    assign unused_br_lsbs = ^br_addr[1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        inst_d    = inst_q;
        issued_d  = 1'b0;

        if (br && (state_q != IF_IDLE)) begin
            // issued_d stays 0, so a response to a request granted now is dropped.
            pc_d      = {br_addr[31:2], 2'b00};
            req_cnt_d = 3'd0;
            rsp_cnt_d = 3'd0;
            inst_d    = 32'd0;
            state_d   = IF_FETCH;
        end else begin
            if (byte_take) begin
                inst_d[{rsp_cnt_q[1:0], 3'b000} +: 8] = mem_rdata;
                rsp_cnt_d = rsp_cnt_q + 3'd1;
            end
            if (grant) begin
                req_cnt_d = req_cnt_q + 3'd1;
                issued_d  = 1'b1;
            end

            case (state_q)
                IF_IDLE:  state_d = IF_FETCH;
                IF_FETCH: begin
                    if (last_grant) begin
                        state_d = last_byte ? IF_VALID : IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (last_byte) begin
                        state_d = IF_VALID;
                    end
                end
                IF_VALID: begin
                    if (if_ready) begin
                        pc_d      = pc_q + 32'd4;
                        req_cnt_d = 3'd0;
                        rsp_cnt_d = 3'd0;
                        state_d   = IF_FETCH;
                    end
                end
                default:  state_d = IF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IF_IDLE;
            pc_q      <= RESET_PC;
            req_cnt_q <= 3'd0;
            rsp_cnt_q <= 3'd0;
            inst_q    <= 32'd0;
            issued_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            inst_q    <= inst_d;
            issued_q  <= issued_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, hand-written
// corner sequences, then random traffic against a stream-level reference model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [31:0] br_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:1023];
    logic        pendValid;
    logic [31:0] pendAddr;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .br         (br),
        .br_addr    (br_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_inst    (if_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        ready;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInst;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {mem[10'(a + 32'd3)], mem[10'(a + 32'd2)], mem[10'(a + 32'd1)], mem[10'(a)]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive inputs for this cycle (memory responder included), then settle to the negedge.
    task automatic applyStimulus(input logic g, input logic r, input logic b, input logic [31:0] ba);
        mem_gnt    = g;
        if_ready   = r;
        br         = b;
        br_addr    = ba;
        mem_rvalid = pendValid;
        mem_rdata  = pendValid ? mem[10'(pendAddr)] : 8'($urandom);
        @(negedge clk);
    endtask

    task automatic finishCycle();
        logic        g;
        logic [31:0] a;
        g = mem_req && mem_gnt;
        a = mem_addr;
        @(posedge clk);
        #1;
        pendValid = g;
        pendAddr  = a;
    endtask

    task automatic doReset();
        rst       = 1'b0;
        mem_gnt   = 1'b0;
        if_ready  = 1'b0;
        br        = 1'b0;
        br_addr   = 32'h0;
        pendValid = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Leaves the bench at the negedge of the first valid cycle; n = cycles waited.
    task automatic waitValid(input int maxC, output int n);
        n = -1;
        for (int i = 0; i < maxC; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            if (if_valid) begin
                n = i;
                break;
            end
            finishCycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        int n;
        int grantIdx;
        int firstValid;
        logic [31:0] instAtValid;
        logic [31:0] prevAddr;
        logic prevStall;
        logic [31:0] expPc;
        int grants;
        int idle;
        int transfers;
        logic g, r, b;
        logic [31:0] ba;

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
        mem[4] = 8'h13; mem[5] = 8'h01; mem[6] = 8'ha0; mem[7] = 8'h00;
        mem[10'h100] = 8'h37; mem[10'h101] = 8'h05; mem[10'h102] = 8'h00; mem[10'h103] = 8'h10;

        // Reset values while reset is held.
        rst = 1'b0; mem_gnt = 1'b1; if_ready = 1'b1; br = 1'b0; br_addr = 32'h0;
        mem_rvalid = 1'b0; mem_rdata = 8'h0; pendValid = 1'b0; pendAddr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset mem_addr", mem_addr, RESET_PC);
        checkOutput("reset if_valid", 32'(if_valid), 32'd0);
        checkOutput("reset if_pc", if_pc, RESET_PC);
        checkOutput("reset if_inst", if_inst, 32'd0);

        // Row 0 is the IDLE cycle after release; rows 1.. are FETCH cycles 0..7.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h3, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h4, 1'b1, 32'h0, 32'h00500093};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 32'h4, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h5, 1'b0, 32'h4, 32'h0};

        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].gnt, vecs[i].ready, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(vecs[i].expReq));
            checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d if_pc", i), if_pc, vecs[i].expPc);
            if (vecs[i].expValid) checkOutput($sformatf("vec%0d if_inst", i), if_inst, vecs[i].expInst);
            finishCycle();
        end

        // Backpressure: hold VALID for 10 cycles, then accept.
        waitValid(20, n);
        checkOutput("stall valid latency", 32'(n), 32'd3);
        finishCycle();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("stall if_valid", 32'(if_valid), 32'd1);
            checkOutput("stall if_pc", if_pc, 32'h4);
            checkOutput("stall if_inst", if_inst, 32'h00A00113);
            checkOutput("stall mem_req", 32'(mem_req), 32'd0);
            finishCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        finishCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("after accept mem_req", 32'(mem_req), 32'd1);
        checkOutput("after accept mem_addr", mem_addr, 32'h8);
        finishCycle();

        // Alternating grant: address held while denied, valid in cycle 9.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        finishCycle();
        grantIdx = 0; firstValid = -1; instAtValid = 32'h0; prevStall = 1'b0; prevAddr = 32'h0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'(c % 2), 1'b0, 1'b0, 32'h0);
            if (prevStall) checkOutput("alt addr held", mem_addr, prevAddr);
            prevStall = mem_req && !mem_gnt;
            prevAddr  = mem_addr;
            if (mem_req && mem_gnt) begin
                checkOutput("alt grant addr", mem_addr, 32'(grantIdx));
                grantIdx++;
            end
            if (if_valid && firstValid < 0) begin
                firstValid  = c;
                instAtValid = if_inst;
            end
            finishCycle();
        end
        checkOutput("alt grant count", 32'(grantIdx), 32'd4);
        checkOutput("alt first valid cycle", 32'(firstValid), 32'd9);
        checkOutput("alt inst", instAtValid, 32'h00500093);

        // Branch in WAIT while the last byte is in flight.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        finishCycle();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            finishCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h103);
        checkOutput("wait br mem_req", 32'(mem_req), 32'd0);
        checkOutput("wait br if_valid", 32'(if_valid), 32'd0);
        finishCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("br target mem_req", 32'(mem_req), 32'd1);
        checkOutput("br target mem_addr", mem_addr, 32'h100);
        finishCycle();
        waitValid(20, n);
        checkOutput("br target latency", 32'(n), 32'd4);
        checkOutput("br target if_pc", if_pc, 32'h100);
        checkOutput("br target if_inst", if_inst, 32'h10000537);

        // Branch and ready together in VALID: gated, no transfer, refetch.
        br = 1'b1; br_addr = 32'h4; if_ready = 1'b1;
        #1;
        checkOutput("br+ready if_valid", 32'(if_valid), 32'd0);
        finishCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("br+ready if_pc", if_pc, 32'h4);
        checkOutput("br+ready mem_addr", mem_addr, 32'h4);
        finishCycle();
        waitValid(20, n);
        checkOutput("br+ready latency", 32'(n), 32'd4);
        checkOutput("br+ready if_inst", if_inst, 32'h00A00113);
        if_ready = 1'b1;
        finishCycle();

        // Asynchronous reset in the middle of FETCH.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("pre-reset mem_req", 32'(mem_req), 32'd1);
        checkOutput("pre-reset mem_addr", mem_addr, 32'h8);
        finishCycle();
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'hFF;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("async reset if_valid", 32'(if_valid), 32'd0);
        checkOutput("async reset mem_addr", mem_addr, RESET_PC);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pendValid = 1'b1;
        pendAddr  = 32'h9;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("post-reset idle mem_req", 32'(mem_req), 32'd0);
        finishCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("post-reset mem_addr", mem_addr, RESET_PC);
        checkOutput("post-reset mem_req", 32'(mem_req), 32'd1);
        finishCycle();
        waitValid(20, n);
        checkOutput("post-reset latency", 32'(n), 32'd4);
        checkOutput("post-reset if_inst", if_inst, 32'h00500093);

        // Random traffic against a stream-level model: the instruction stream
        // is RESET_PC, +4 per accepted word, restarting at each branch target.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        finishCycle();
        expPc = RESET_PC; grants = 0; idle = 0; transfers = 0;
        for (int i = 0; i < 3000; i++) begin
            g  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            b  = ($urandom_range(0, 19) == 0);
            ba = 32'($urandom_range(0, 1023));
            applyStimulus(g, r, b, ba);
            idle++;
            if (b) begin
                checkOutput("rand br gates valid", 32'(if_valid), 32'd0);
                expPc = {ba[31:2], 2'b00};
                grants = 0;
                idle = 0;
            end else if (if_valid) begin
                checkOutput("rand if_pc", if_pc, expPc);
                checkOutput("rand if_inst", if_inst, memWord(expPc));
                checkOutput("rand mem_req in valid", 32'(mem_req), 32'd0);
                if (r) begin
                    expPc = expPc + 32'd4;
                    grants = 0;
                    idle = 0;
                    transfers++;
                end
            end else if (mem_req && mem_gnt) begin
                checkOutput("rand grant addr", mem_addr, expPc + 32'(grants));
                grants++;
            end
            if (idle > 100) begin
                checkOutput("rand progress", 32'(idle), 32'd0);
                break;
            end
            finishCycle();
        end
        checkOutput("rand transfers seen", 32'(transfers > 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
